terminal_write_engine: RTL and testbench

- Character-terminal write controller for the parametrised text display; it replaces the cursor, scroll and clear logic that used to sit inside the display core.
- Accepts CPU characters through a small FIFO with a ready handshake.
- Translates characters into VRAM writes at the hardware cursor, with auto-wrap, backspace and circular-buffer scrolling.
- Drives the VRAM write port, plus the start_row/cursor outputs that the video scanner uses for readout and cursor blink.

---
 rtl/terminal_write_engine.sv | 225 ++++++++++++++++++++++
 tb/tb_terminal_write_engine.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/terminal_write_engine.sv
// Character-terminal write engine: buffers CPU bytes, moves the hardware cursor,
// and issues VRAM writes for printing, backspace, scrolling and full-screen clear.
module terminal_write_engine #(
   parameter int COLS           = 40,
   parameter int ROWS           = 24,
   parameter int FIFO_DEPTH     = 4,
   parameter int CLEAR_ON_RESET = 1,
   parameter int COL_W          = $clog2(COLS),
   parameter int ROW_W          = $clog2(ROWS)
) (
   input  logic                   sys_clock,
   input  logic                   reset,
   input  logic                   cpu_clken,
   input  logic                   wr_en,
   input  logic [7:0]             din,
   input  logic                   clr_screen,
   output logic                   ready,
   output logic                   busy,
   output logic                   vram_w_en,
   output logic [ROW_W+COL_W-1:0] vram_w_addr,
   output logic [5:0]             vram_din,
   output logic [ROW_W-1:0]       start_row,
   output logic [ROW_W-1:0]       cursor_row,
   output logic [COL_W-1:0]       cursor_col,
   output logic [1:0]             dbg_state_o
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SCROLL, S_CLEAR} state_t;

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int AW    = ROW_W + COL_W;
   localparam logic [COL_W-1:0] COLS_M1   = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROWS_M1   = ROW_W'(ROWS - 1);
   localparam logic [ROW_W:0]   ROWS_EXT  = (ROW_W+1)'(ROWS);
   localparam logic [PTR_W:0]   DEPTH_EXT = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [5:0]       SPACE     = 6'd32;

   state_t           state_q, state_d;
   logic [7:0]       fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wptr_q, rptr_q;
   logic [PTR_W:0]   count_q;
   logic [7:0]       char_q, char_d;
   logic [ROW_W-1:0] start_row_q, start_row_d;
   logic [ROW_W-1:0] cur_row_q, cur_row_d;
   logic [COL_W-1:0] cur_col_q, cur_col_d;
   logic [ROW_W-1:0] cnt_row_q, cnt_row_d;
   logic [COL_W-1:0] cnt_col_q, cnt_col_d;
   logic             we_q, we_d;
   logic [AW-1:0]    waddr_q, waddr_d;
   logic [5:0]       wdata_q, wdata_d;

   logic             full, empty, push, pop, flush, line_adv;
   logic [ROW_W:0]   phys_sum;
   logic [ROW_W-1:0] phys_row, start_row_inc;
   logic [COL_W-1:0] col_dec;

   assign full          = (count_q == DEPTH_EXT);
   assign empty         = (count_q == '0);
   assign ready         = ~full & (state_q != S_CLEAR);
   assign busy          = (state_q != S_IDLE) | ~empty;
   assign push          = cpu_clken & wr_en & ready;
   assign phys_sum      = {1'b0, start_row_q} + {1'b0, cur_row_q};
   assign phys_row      = (phys_sum >= ROWS_EXT) ? ROW_W'(phys_sum - ROWS_EXT) : phys_sum[ROW_W-1:0];
   assign start_row_inc = (start_row_q == ROWS_M1) ? '0 : start_row_q + ROW_W'(1);
   assign col_dec       = cur_col_q - COL_W'(1);

   assign vram_w_en   = we_q;
   assign vram_w_addr = waddr_q;
   assign vram_din    = wdata_q;
   assign start_row   = start_row_q;
   assign cursor_row  = cur_row_q;
   assign cursor_col  = cur_col_q;
   assign dbg_state_o = state_q;

   always_comb begin
      state_d     = state_q;
      char_d      = char_q;
      start_row_d = start_row_q;
      cur_row_d   = cur_row_q;
      cur_col_d   = cur_col_q;
      cnt_row_d   = cnt_row_q;
      cnt_col_d   = cnt_col_q;
      we_d        = 1'b0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      pop         = 1'b0;
      flush       = 1'b0;
      line_adv    = 1'b0;
      if (clr_screen) begin
         // A clear request pre-empts any operation and restarts the sweep.
         state_d     = S_CLEAR;
         flush       = 1'b1;
         start_row_d = '0;
         cur_row_d   = '0;
         cur_col_d   = '0;
         cnt_row_d   = '0;
         cnt_col_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!empty) begin
                  pop     = 1'b1;
                  char_d  = fifo_mem_q[rptr_q];
                  state_d = S_EXEC;
               end
            end
            S_EXEC: begin
               state_d = S_IDLE;
               case (char_q)
                  8'h0D, 8'h8D: begin
                     cur_col_d = '0;
                     line_adv  = 1'b1;
                  end
                  8'h08, 8'h88: begin
                     if (cur_col_q != '0) begin
                        cur_col_d = col_dec;
                        we_d      = 1'b1;
                        waddr_d   = {phys_row, col_dec};
                        wdata_d   = SPACE;
                     end
                  end
                  8'h00, 8'h0A, 8'h7F, 8'h9B: ;
                  default: begin
                     we_d    = 1'b1;
                     waddr_d = {phys_row, cur_col_q};
                     wdata_d = {~char_q[6], char_q[4:0]};
                     if (cur_col_q == COLS_M1) begin
                        cur_col_d = '0;
                        line_adv  = 1'b1;
                     end else begin
                        cur_col_d = cur_col_q + COL_W'(1);
                     end
                  end
               endcase
               if (line_adv) begin
                  if (cur_row_q != ROWS_M1) begin
                     cur_row_d = cur_row_q + ROW_W'(1);
                  end else begin
                     // The old top row becomes the new bottom row and is blanked.
                     start_row_d = start_row_inc;
                     cnt_row_d   = start_row_q;
                     cnt_col_d   = '0;
                     state_d     = S_SCROLL;
                  end
               end
            end
            S_SCROLL: begin
               we_d    = 1'b1;
               waddr_d = {cnt_row_q, cnt_col_q};
               wdata_d = SPACE;
               if (cnt_col_q == COLS_M1) state_d = S_IDLE;
               else cnt_col_d = cnt_col_q + COL_W'(1);
            end
            S_CLEAR: begin
               we_d    = 1'b1;
               waddr_d = {cnt_row_q, cnt_col_q};
               wdata_d = SPACE;
               if (cnt_col_q == COLS_M1) begin
                  cnt_col_d = '0;
                  if (cnt_row_q == ROWS_M1) begin
                     cnt_row_d = '0;
                     state_d   = S_IDLE;
                  end else begin
                     cnt_row_d = cnt_row_q + ROW_W'(1);
                  end
               end else begin
                  cnt_col_d = cnt_col_q + COL_W'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clock or posedge reset) begin
      if (reset) begin
         state_q     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
         char_q      <= '0;
         start_row_q <= '0;
         cur_row_q   <= '0;
         cur_col_q   <= '0;
         cnt_row_q   <= '0;
         cnt_col_q   <= '0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         char_q      <= char_d;
         start_row_q <= start_row_d;
         cur_row_q   <= cur_row_d;
         cur_col_q   <= cur_col_d;
         cnt_row_q   <= cnt_row_d;
         cnt_col_q   <= cnt_col_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
      end
   end

   always_ff @(posedge sys_clock or posedge reset) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else if (flush) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + PTR_W'(1);
         if (pop)  rptr_q <= rptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge sys_clock) begin
      if (push && !flush) fifo_mem_q[wptr_q] <= din;
   end

endmodule

// File: tb/tb_terminal_write_engine.sv
// Randomised bench for terminal_write_engine: a per-character screen model
// predicts every VRAM write; a negedge monitor checks them in order.
module tb_terminal_write_engine;
   localparam int COLS  = 40;
   localparam int ROWS  = 24;
   localparam int COL_W = $clog2(COLS);
   localparam int ROW_W = $clog2(ROWS);
   localparam int AW    = ROW_W + COL_W;
   localparam int EW    = AW + 6;

   logic             sys_clock = 1'b0;
   logic             reset = 1'b1;
   logic             cpu_clken = 1'b0;
   logic             wr_en = 1'b0;
   logic [7:0]       din = 8'h00;
   logic             clr_screen = 1'b0;
   logic             ready, busy, vram_w_en;
   logic [AW-1:0]    vram_w_addr;
   logic [5:0]       vram_din;
   logic [ROW_W-1:0] start_row, cursor_row;
   logic [COL_W-1:0] cursor_col;
   logic [1:0]       dbg_state;

   terminal_write_engine #(.COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(4), .CLEAR_ON_RESET(1)) dut (
      .sys_clock(sys_clock), .reset(reset), .cpu_clken(cpu_clken), .wr_en(wr_en),
      .din(din), .clr_screen(clr_screen), .ready(ready), .busy(busy),
      .vram_w_en(vram_w_en), .vram_w_addr(vram_w_addr), .vram_din(vram_din),
      .start_row(start_row), .cursor_row(cursor_row), .cursor_col(cursor_col),
      .dbg_state_o(dbg_state)
   );

   always #5 sys_clock = ~sys_clock;

   int checks = 0;
   int errors = 0;
   logic [EW-1:0] exp_q[$];
   bit mon_en = 1'b0;
   int m_row = 0, m_col = 0, m_start = 0;

   function automatic logic [EW-1:0] pack(input int r, input int c, input logic [5:0] d);
      return {ROW_W'(r), COL_W'(c), d};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic expect_clear();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            exp_q.push_back(pack(r, c, 6'd32));
   endtask

   task automatic model_advance();
      int old;
      if (m_row < ROWS - 1) begin
         m_row++;
      end else begin
         old = m_start;
         m_start = (m_start + 1) % ROWS;
         for (int c = 0; c < COLS; c++) exp_q.push_back(pack(old, c, 6'd32));
      end
   endtask

   task automatic model_char(input logic [7:0] b);
      int phys;
      phys = (m_start + m_row) % ROWS;
      case (b)
         8'h0D, 8'h8D: begin
            m_col = 0;
            model_advance();
         end
         8'h08, 8'h88: begin
            if (m_col > 0) begin
               m_col--;
               exp_q.push_back(pack(phys, m_col, 6'd32));
            end
         end
         8'h00, 8'h0A, 8'h7F, 8'h9B: ;
         default: begin
            exp_q.push_back(pack(phys, m_col, {~b[6], b[4:0]}));
            if (m_col == COLS - 1) begin
               m_col = 0;
               model_advance();
            end else begin
               m_col++;
            end
         end
      endcase
   endtask

   function automatic logic [7:0] rand_print();
      logic [7:0] b;
      do b = 8'($urandom_range(0, 255));
      while (b inside {8'h00, 8'h0A, 8'h7F, 8'h9B, 8'h0D, 8'h8D, 8'h08, 8'h88});
      return b;
   endfunction

   task automatic push_char(input logic [7:0] b, input bit use_model);
      int n = 0;
      while (!ready && n < 3000) begin
         @(posedge sys_clock); #1;
         n++;
      end
      if (!ready) begin
         errors++;
         $display("FAIL push_timeout: ready stayed low for %0d cycles", n);
      end
      cpu_clken = 1'b1;
      wr_en = 1'b1;
      din = b;
      @(posedge sys_clock); #1;
      wr_en = 1'b0;
      if (use_model) model_char(b);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < 3000) begin
         @(posedge sys_clock); #1;
         n++;
      end
      if (n >= 3000) begin
         errors++;
         $display("FAIL idle_timeout: busy=%0d pending=%0d after %0d cycles", busy, exp_q.size(), n);
      end
      repeat (3) begin
         @(posedge sys_clock); #1;
      end
   endtask

   task automatic chk_cursor(input string name);
      chk({name, "_row"}, int'(cursor_row), m_row);
      chk({name, "_col"}, int'(cursor_col), m_col);
      chk({name, "_start"}, int'(start_row), m_start);
   endtask

   always @(negedge sys_clock) begin
      logic [EW-1:0] e;
      if (mon_en && vram_w_en) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr=%0h data=%0d with nothing expected", vram_w_addr, vram_din);
         end else begin
            e = exp_q.pop_front();
            if ({vram_w_addr, vram_din} !== e) begin
               errors++;
               $display("FAIL vram_write: got addr=%0h data=%0d expected addr=%0h data=%0d",
                        vram_w_addr, vram_din, e[EW-1:6], e[5:0]);
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      repeat (2) @(posedge sys_clock);
      #1;
      chk("rst_ready", ready, 0);
      chk("rst_busy", busy, 1);
      chk("rst_we", vram_w_en, 0);
      chk("rst_addr", int'(vram_w_addr), 0);
      chk("rst_din", int'(vram_din), 0);
      chk_cursor("rst");

      expect_clear();
      mon_en = 1'b1;
      reset = 1'b0;
      wait_idle();
      chk("post_clear_ready", ready, 1);
      chk("post_clear_busy", busy, 0);
      chk("post_clear_pending", exp_q.size(), 0);

      push_char(8'hC1, 1'b1);
      wait_idle();
      chk("after_A_col", int'(cursor_col), 1);
      push_char(8'h88, 1'b1);
      wait_idle();
      chk("after_bs_col", int'(cursor_col), 0);
      push_char(8'h08, 1'b1);
      wait_idle();
      chk_cursor("bs_at_col0");

      for (int i = 0; i < COLS; i++) push_char(rand_print(), 1'b1);
      wait_idle();
      chk("full_line_row", int'(cursor_row), 1);
      chk("full_line_col", int'(cursor_col), 0);
      chk("full_line_start", int'(start_row), 0);

      while (m_row < ROWS - 1) push_char(8'h0D, 1'b1);
      wait_idle();
      chk_cursor("bottom");
      push_char(8'h8D, 1'b1);
      wait_idle();
      chk("scroll_start", int'(start_row), 1);
      chk("scroll_row", int'(cursor_row), ROWS - 1);
      chk("scroll_col", int'(cursor_col), 0);
      push_char(rand_print(), 1'b1);
      wait_idle();

      // Fill the FIFO while the engine is busy scrolling.
      push_char(8'h8D, 1'b1);
      repeat (3) begin
         @(posedge sys_clock); #1;
      end
      for (int i = 0; i < 4; i++) push_char(rand_print(), 1'b1);
      chk("fifo_full_ready", ready, 0);
      wr_en = 1'b1;
      din = 8'hC5;
      @(posedge sys_clock); #1;
      wr_en = 1'b0;
      wait_idle();
      chk_cursor("fifo_fill");

      for (int i = 0; i < 160; i++) begin
         case ($urandom_range(0, 7))
            0: b = 8'h8D;
            1: b = 8'h88;
            default: b = 8'($urandom_range(0, 255));
         endcase
         push_char(b, 1'b1);
         if ($urandom_range(0, 5) == 0) begin
            cpu_clken = 1'b0;
            wr_en = 1'b1;
            din = 8'hC7;
            @(posedge sys_clock); #1;
            wr_en = 1'b0;
            cpu_clken = 1'b1;
         end
         repeat ($urandom_range(0, 2)) begin
            @(posedge sys_clock); #1;
         end
      end
      wait_idle();
      chk_cursor("random");

      while (m_row < ROWS - 1) push_char(8'h0D, 1'b1);
      wait_idle();
      mon_en = 1'b0;
      push_char(8'h8D, 1'b0);
      repeat (4) begin
         @(posedge sys_clock); #1;
      end
      push_char(8'hC1, 1'b0);
      push_char(8'hC2, 1'b0);
      repeat (6) begin
         @(posedge sys_clock); #1;
      end
      chk("busy_before_clr", busy, 1);
      clr_screen = 1'b1;
      @(posedge sys_clock); #1;
      clr_screen = 1'b0;
      exp_q.delete();
      expect_clear();
      m_row = 0;
      m_col = 0;
      m_start = 0;
      mon_en = 1'b1;
      chk("clr_ready_low", ready, 0);
      wait_idle();
      chk_cursor("after_clr");
      chk("after_clr_busy", busy, 0);
      chk("after_clr_ready", ready, 1);
      push_char(8'hC1, 1'b1);
      wait_idle();
      chk_cursor("after_clr_char");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
